// File: rtl/cpu_fetch_sequencer_if.sv
// Fetch sequencer bus: ROM port, datapath requests, status.
// Parameters must match the attached cpu_fetch_sequencer.
interface cpu_fetch_sequencer_if #(
  parameter int PC_W        = 11,
  parameter int IR_W        = 14,
  parameter int STACK_DEPTH = 8
);
  localparam int SP_W = $clog2(STACK_DEPTH + 1);

  logic            stall;
  logic [IR_W-1:0] rom_data;
  logic [PC_W-1:0] rom_addr;
  logic [IR_W-1:0] ir_out;
  logic [PC_W-1:0] pc_out;
  logic [2:0]      state;
  logic            exec_en;
  logic            branch_req;
  logic            call_req;
  logic            ret_req;
  logic            skip_req;
  logic [PC_W-1:0] target;
  logic [SP_W-1:0] stack_ptr;
  logic            stack_ovf;
  logic            stack_unf;
  logic            clear_flags;

  modport master (
    output stall, rom_data,
    output branch_req, call_req,
    output ret_req, skip_req,
    output target, clear_flags,
    input  rom_addr, ir_out, pc_out,
    input  state, exec_en,
    input  stack_ptr, stack_ovf,
    input  stack_unf
  );

  modport slave (
    input  stall, rom_data,
    input  branch_req, call_req,
    input  ret_req, skip_req,
    input  target, clear_flags,
    output rom_addr, ir_out, pc_out,
    output state, exec_en,
    output stack_ptr, stack_ovf,
    output stack_unf
  );
endinterface

// File: rtl/cpu_fetch_sequencer.sv
// Fetch/sequencing unit: PC, MAR, IR, T0..T6 FSM,
// hardware call/return stack with sticky fault flags.
module cpu_fetch_sequencer #(
  parameter int PC_W         = 11,
  parameter int IR_W         = 14,
  parameter int STACK_DEPTH  = 8,
  parameter int RESET_VECTOR = 0,
  parameter int STACK_WRAP   = 1
) (
  input logic clk,
  input logic reset_n,
  cpu_fetch_sequencer_if.slave bus
);

  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = $clog2(STACK_DEPTH);

  localparam logic [PC_W-1:0] RV =
    PC_W'(RESET_VECTOR);
  localparam logic [SP_W-1:0] FULL =
    SP_W'(STACK_DEPTH);

  typedef enum logic [2:0] {
    T0 = 3'd0,
    T1 = 3'd1,
    T2 = 3'd2,
    T3 = 3'd3,
    T4 = 3'd4,
    T5 = 3'd5,
    T6 = 3'd6
  } state_t;

  state_t          st;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] mar;
  logic [IR_W-1:0] ir;
  logic [SP_W-1:0] sp;
  logic            ovf;
  logic            unf;
  logic [PC_W-1:0] stk [STACK_DEPTH];

  // Entry stk[0] is the oldest; the top
  // of stack sits at stk[sp-1].
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] top_idx;

  assign wr_idx  = sp[IDX_W-1:0];
  assign top_idx = wr_idx - IDX_W'(1);

  // Instruction cycle, request handling and
  // stack; stall freezes every register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st  <= T0;
      pc  <= RV;
      mar <= '0;
      ir  <= '0;
      sp  <= '0;
      ovf <= 1'b0;
      unf <= 1'b0;
      for (int i = 0; i < STACK_DEPTH; i++)
        stk[i] <= '0;
    end else if (!bus.stall) begin
      // Clear first so a same-cycle set wins.
      if (bus.clear_flags) begin
        ovf <= 1'b0;
        unf <= 1'b0;
      end
      case (st)
        T0: st <= T1;
        T1: begin
          mar <= pc;
          st  <= T2;
        end
        T2: begin
          pc <= pc + PC_W'(1);
          st <= T3;
        end
        T3: begin
          ir <= bus.rom_data;
          st <= T4;
        end
        T4: begin
          st <= T5;
          priority case (1'b1)
            bus.ret_req: begin
              if (sp != '0) begin
                pc <= stk[top_idx];
                sp <= sp - SP_W'(1);
              end else begin
                pc  <= RV;
                unf <= 1'b1;
              end
            end
            bus.call_req: begin
              pc <= bus.target;
              if (sp < FULL) begin
                stk[wr_idx] <= pc;
                sp <= sp + SP_W'(1);
              end else begin
                ovf <= 1'b1;
                if (STACK_WRAP != 0) begin
                  for (int i = 0; i < STACK_DEPTH - 1; i++)
                    stk[i] <= stk[i+1];
                  stk[STACK_DEPTH-1] <= pc;
                end
              end
            end
            bus.branch_req: pc <= bus.target;
            bus.skip_req:   pc <= pc + PC_W'(1);
            default: ;
          endcase
        end
        T5: st <= T6;
        T6: st <= T1;
        default: st <= T0;
      endcase
    end
  end

  // Execute strobe is suppressed by stall.
  assign bus.exec_en   = (st == T4) && !bus.stall;
  assign bus.state     = st;
  assign bus.pc_out    = pc;
  assign bus.rom_addr  = mar;
  assign bus.ir_out    = ir;
  assign bus.stack_ptr = sp;
  assign bus.stack_ovf = ovf;
  assign bus.stack_unf = unf;

endmodule

// File: tb/tb_cpu_fetch_sequencer.sv
// Bench: two sequencers (wrap / no-wrap) in lockstep,
// table-driven T4 requests plus stack and stall sequences.
module tb_cpu_fetch_sequencer;

  logic clk;
  logic reset_n;
  int   total;
  int   bad;

  cpu_fetch_sequencer_if #(
    .PC_W(11), .IR_W(14), .STACK_DEPTH(8)
  ) ia ();
  cpu_fetch_sequencer_if #(
    .PC_W(11), .IR_W(14), .STACK_DEPTH(8)
  ) ib ();

  cpu_fetch_sequencer #(
    .PC_W(11), .IR_W(14), .STACK_DEPTH(8),
    .RESET_VECTOR(0), .STACK_WRAP(1)
  ) dut_a (
    .clk(clk), .reset_n(reset_n), .bus(ia)
  );

  cpu_fetch_sequencer #(
    .PC_W(11), .IR_W(14), .STACK_DEPTH(8),
    .RESET_VECTOR(0), .STACK_WRAP(0)
  ) dut_b (
    .clk(clk), .reset_n(reset_n), .bus(ib)
  );

  function automatic logic [13:0] rom_f(
    input logic [10:0] a
  );
    return 14'h2000 | {3'b000, a};
  endfunction

  assign ia.rom_data    = rom_f(ia.rom_addr);
  assign ib.rom_data    = rom_f(ib.rom_addr);
  assign ib.stall       = ia.stall;
  assign ib.branch_req  = ia.branch_req;
  assign ib.call_req    = ia.call_req;
  assign ib.ret_req     = ia.ret_req;
  assign ib.skip_req    = ia.skip_req;
  assign ib.target      = ia.target;
  assign ib.clear_flags = ia.clear_flags;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic        ret;
    logic        call;
    logic        br;
    logic        skip;
    logic        clr;
    logic [10:0] tgt;
    logic [10:0] pc;
    logic [3:0]  sp;
    logic        unf;
    logic [13:0] ir;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(
    input string       name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h",
               name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input int s);
    int n;
    n = 0;
    while (int'(ia.state) != s && n < 10) begin
      tick();
      n++;
    end
    chk("reach_state", 32'(ia.state), s);
  endtask

  task automatic clr_req();
    ia.ret_req     = 1'b0;
    ia.call_req    = 1'b0;
    ia.branch_req  = 1'b0;
    ia.skip_req    = 1'b0;
    ia.clear_flags = 1'b0;
  endtask

  task automatic do_req(
    input logic r, input logic c,
    input logic b, input logic s,
    input logic cl, input logic [10:0] t
  );
    wait_state(4);
    chk("exec_en_t4", 32'(ia.exec_en), 1);
    ia.ret_req     = r;
    ia.call_req    = c;
    ia.branch_req  = b;
    ia.skip_req    = s;
    ia.clear_flags = cl;
    ia.target      = t;
    tick();
    clr_req();
  endtask

  logic [10:0] v [9];
  int          ex_cnt;

  initial begin
    total = 0;
    bad   = 0;

    tbl[0]  = '{0,0,1,0,0, 11'h005, 11'h005, 0, 0, 14'h2004};
    tbl[1]  = '{0,1,0,0,0, 11'h100, 11'h100, 1, 0, 14'h2005};
    tbl[2]  = '{1,0,0,0,0, 11'h000, 11'h006, 0, 0, 14'h2100};
    tbl[3]  = '{0,0,1,1,0, 11'h050, 11'h050, 0, 0, 14'h2006};
    tbl[4]  = '{0,0,0,1,0, 11'h000, 11'h052, 0, 0, 14'h2050};
    tbl[5]  = '{0,0,0,0,0, 11'h000, 11'h053, 0, 0, 14'h2052};
    tbl[6]  = '{0,1,1,0,0, 11'h200, 11'h200, 1, 0, 14'h2053};
    tbl[7]  = '{1,1,0,1,0, 11'h300, 11'h054, 0, 0, 14'h2200};
    tbl[8]  = '{0,0,1,0,0, 11'h7FF, 11'h7FF, 0, 0, 14'h2054};
    tbl[9]  = '{0,0,0,1,0, 11'h000, 11'h001, 0, 0, 14'h27FF};
    tbl[10] = '{1,0,0,0,0, 11'h000, 11'h000, 0, 1, 14'h2001};
    tbl[11] = '{0,0,0,0,1, 11'h000, 11'h001, 0, 0, 14'h2000};

    reset_n  = 1'b0;
    ia.stall = 1'b0;
    ia.target = '0;
    clr_req();
    #3;
    chk("rst_state", 32'(ia.state), 0);
    chk("rst_pc", 32'(ia.pc_out), 0);
    chk("rst_addr", 32'(ia.rom_addr), 0);
    chk("rst_ir", 32'(ia.ir_out), 0);
    chk("rst_sp", 32'(ia.stack_ptr), 0);
    chk("rst_ovf", 32'(ia.stack_ovf), 0);
    chk("rst_unf", 32'(ia.stack_unf), 0);
    chk("rst_exec", 32'(ia.exec_en), 0);
    tick();
    reset_n = 1'b1;

    // Free run: six-state loop T1..T6 after T0.
    ex_cnt = 0;
    for (int k = 1; k <= 24; k++) begin
      int es;
      tick();
      es = ((k - 1) % 6) + 1;
      chk("run_state", 32'(ia.state), es);
      chk("run_addr", 32'(ia.rom_addr),
          (k < 2) ? 0 : (k - 2) / 6);
      chk("run_exec", 32'(ia.exec_en),
          (es == 4) ? 1 : 0);
      if (ia.exec_en) ex_cnt++;
    end
    chk("run_exec_cnt", ex_cnt, 4);
    chk("run_pc", 32'(ia.pc_out), 4);
    chk("run_ir", 32'(ia.ir_out), 14'h2003);

    // Table of T4 requests.
    for (int i = 0; i < 12; i++) begin
      do_req(tbl[i].ret, tbl[i].call,
             tbl[i].br, tbl[i].skip,
             tbl[i].clr, tbl[i].tgt);
      chk($sformatf("tbl%0d_pc", i),
          32'(ia.pc_out), 32'(tbl[i].pc));
      chk($sformatf("tbl%0d_sp", i),
          32'(ia.stack_ptr), 32'(tbl[i].sp));
      chk($sformatf("tbl%0d_unf", i),
          32'(ia.stack_unf), 32'(tbl[i].unf));
      chk($sformatf("tbl%0d_ovf", i),
          32'(ia.stack_ovf), 0);
      chk($sformatf("tbl%0d_ir", i),
          32'(ia.ir_out), 32'(tbl[i].ir));
      chk($sformatf("tbl%0d_pc_b", i),
          32'(ib.pc_out), 32'(tbl[i].pc));
    end

    // Nine nested calls; the ninth overflows.
    v[0] = 11'h002;
    for (int k = 1; k < 9; k++)
      v[k] = 11'h100 + 11'(16 * (k - 1)) + 11'h1;
    for (int k = 0; k < 9; k++) begin
      do_req(0, 1, 0, 0, (k == 8),
             11'h100 + 11'(16 * k));
      chk("call_pc", 32'(ia.pc_out),
          32'h100 + 16 * k);
      chk("call_sp_a", 32'(ia.stack_ptr),
          (k < 8) ? k + 1 : 8);
      chk("call_sp_b", 32'(ib.stack_ptr),
          (k < 8) ? k + 1 : 8);
      chk("call_ovf_a", 32'(ia.stack_ovf),
          (k == 8) ? 1 : 0);
      chk("call_ovf_b", 32'(ib.stack_ovf),
          (k == 8) ? 1 : 0);
    end

    // Nine returns: LIFO, then underflow.
    for (int j = 0; j < 9; j++) begin
      do_req(1, 0, 0, 0, 0, 11'h000);
      chk("ret_pc_a", 32'(ia.pc_out),
          (j < 8) ? 32'(v[8-j]) : 0);
      chk("ret_pc_b", 32'(ib.pc_out),
          (j < 8) ? 32'(v[7-j]) : 0);
      chk("ret_sp_a", 32'(ia.stack_ptr),
          (j < 8) ? 7 - j : 0);
      chk("ret_sp_b", 32'(ib.stack_ptr),
          (j < 8) ? 7 - j : 0);
      chk("ret_unf_a", 32'(ia.stack_unf),
          (j == 8) ? 1 : 0);
      chk("ret_unf_b", 32'(ib.stack_unf),
          (j == 8) ? 1 : 0);
      chk("ret_ovf_a", 32'(ia.stack_ovf), 1);
    end

    // Clear is blocked by stall, honoured in T5.
    ia.stall       = 1'b1;
    ia.clear_flags = 1'b1;
    tick();
    chk("stall_clr_state", 32'(ia.state), 5);
    chk("stall_clr_unf", 32'(ia.stack_unf), 1);
    chk("stall_clr_ovf", 32'(ia.stack_ovf), 1);
    ia.stall = 1'b0;
    tick();
    ia.clear_flags = 1'b0;
    chk("clr_state", 32'(ia.state), 6);
    chk("clr_unf", 32'(ia.stack_unf), 0);
    chk("clr_ovf", 32'(ia.stack_ovf), 0);

    // Three calls, then stall in T3.
    do_req(0, 1, 0, 0, 0, 11'h400);
    do_req(0, 1, 0, 0, 0, 11'h410);
    do_req(0, 1, 0, 0, 0, 11'h420);
    chk("c3_sp", 32'(ia.stack_ptr), 3);
    wait_state(3);
    chk("t3_ir", 32'(ia.ir_out), 14'h2410);
    chk("t3_pc", 32'(ia.pc_out), 11'h421);
    chk("t3_addr", 32'(ia.rom_addr), 11'h420);
    ia.stall   = 1'b1;
    ia.ret_req = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("stl_state", 32'(ia.state), 3);
      chk("stl_ir", 32'(ia.ir_out), 14'h2410);
      chk("stl_pc", 32'(ia.pc_out), 11'h421);
      chk("stl_sp", 32'(ia.stack_ptr), 3);
      chk("stl_exec", 32'(ia.exec_en), 0);
    end
    ia.stall   = 1'b0;
    ia.ret_req = 1'b0;
    tick();
    chk("unstl_state", 32'(ia.state), 4);
    chk("unstl_ir", 32'(ia.ir_out), 14'h2420);
    chk("unstl_exec", 32'(ia.exec_en), 1);
    chk("unstl_sp", 32'(ia.stack_ptr), 3);

    // Async reset in T4 with three entries.
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_state", 32'(ia.state), 0);
    chk("arst_pc", 32'(ia.pc_out), 0);
    chk("arst_addr", 32'(ia.rom_addr), 0);
    chk("arst_ir", 32'(ia.ir_out), 0);
    chk("arst_sp", 32'(ia.stack_ptr), 0);
    chk("arst_ovf", 32'(ia.stack_ovf), 0);
    chk("arst_unf", 32'(ia.stack_unf), 0);
    chk("arst_exec", 32'(ia.exec_en), 0);
    chk("arst_sp_b", 32'(ib.stack_ptr), 0);
    chk("arst_pc_b", 32'(ib.pc_out), 0);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
